ram_rd_check: RTL and testbench

//  Read-side controller for the simple dual-port RAM datapath. On a start pulse from the write side it

---
 rtl/ram_rd_check_pkg.sv | 25 ++
 rtl/ram_rd_check_if.sv | 49 ++++
 rtl/ram_rd_check_rd_lat_pipe.sv | 37 +++
 rtl/ram_rd_check.sv | 128 ++++++++++++
 tb/tb_ram_rd_check.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ram_rd_check_pkg.sv
// Shared definitions for the RAM read-side checker: FSM encoding, default geometry, expected pattern.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ram_rd_check_pkg;

  // Two-bit state encoding, shared with the write side so both agree on the sweep phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_DEPTH     = 32;
  localparam int DEF_AW        = 5;
  localparam int DEF_DW        = 8;
  localparam int DEF_DATA_BASE = 0;

  // Expected word for an address before truncation to the data width.
  // The write side stores the same pattern, so callers keep only the low DW bits.
  function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic [31:0] base);
    return addr + base;
  endfunction

endpackage

// File: rtl/ram_rd_check_if.sv
// Signal bundle between the read checker, the RAM read port and its consumer.
// Latency: n/a (wires only).
// Backpressure: none; rd_vld beats cannot be stalled by the consumer.
interface ram_rd_check_if
  import ram_rd_check_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          start;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          err_flag;
  logic [AW:0]   err_cnt;

  // Checker side: drives the RAM read port and the status/beat outputs.
  modport master (
    input  start,
    input  ram_rd_data,
    output ram_rd_en,
    output ram_rd_addr,
    output rd_vld,
    output rd_data,
    output busy,
    output done,
    output err_flag,
    output err_cnt
  );

  // Environment side: write-side start, RAM data return, beat/status consumer.
  modport slave (
    output start,
    output ram_rd_data,
    input  ram_rd_en,
    input  ram_rd_addr,
    input  rd_vld,
    input  rd_data,
    input  busy,
    input  done,
    input  err_flag,
    input  err_cnt
  );

endinterface

// File: rtl/ram_rd_check_rd_lat_pipe.sv
// Delay line carrying {issue-valid, address} alongside the RAM read latency.
// Latency: RD_LAT cycles from in_* to out_*.
// Backpressure: none; shifts every cycle, synchronous reset empties it.
module rd_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int AW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr
);

  logic [RD_LAT-1:0] vld_q;
  logic [AW-1:0]     addr_q [RD_LAT];

  // Shift issue tags one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      addr_q[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_addr = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_rd_check.sv
// Sweeps every RAM address once after start, forwards each word as a beat and checks it (RAM_RD_CHECK_EN).
// Latency: beat for address issued in cycle k appears in k+RD_LAT+1; done coincides with the last beat.
// Backpressure: none; start while busy is dropped, beats are never stalled.
module ram_rd_check
  import ram_rd_check_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int RD_LAT    = 1,
  parameter int DATA_BASE = DEF_DATA_BASE
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  ram_rd_check_if.master bus
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [1:0]    drain_q;
  logic          last_addr;
  logic          start_acc;
  logic          pipe_vld;
  logic [AW-1:0] pipe_addr;
  logic          rd_vld_q;
  logic [DW-1:0] rd_data_q;
  logic          err_flag_q;
  logic [AW:0]   err_cnt_q;

  // Explicit terminal compare; the sweep never depends on the counter wrapping.
  assign last_addr = (addr_q == AW'(DEPTH - 1));
  assign start_acc = (state_q == ST_IDLE) && bus.start;

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: DRAIN lasts RD_LAT cycles so DONE lines up with the final beat's compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_READ;
      ST_READ:  if (last_addr) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == 2'(RD_LAT - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address counter and drain timer; the address parks at 0 outside READ.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      if (state_q == ST_READ) addr_q <= last_addr ? '0 : addr_q + 1'b1;
      if (state_q == ST_DRAIN) drain_q <= drain_q + 1'b1;
      else                     drain_q <= '0;
    end
  end

  // The tag pipe pairs each returning word with the address that fetched it.
  rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .AW     (AW)
  ) u_lat_pipe (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .in_vld   (state_q == ST_READ),
    .in_addr  (addr_q),
    .out_vld  (pipe_vld),
    .out_addr (pipe_addr)
  );

  // Register the returned word; rd_data holds its last beat between beats.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= pipe_vld;
      if (pipe_vld) rd_data_q <= bus.ram_rd_data;
    end
  end

`ifdef RAM_RD_CHECK_EN
  logic [31:0]   exp_full;
  logic [DW-1:0] exp_dat;
  logic          mismatch;

  assign exp_full = exp_word(32'(pipe_addr), 32'(DATA_BASE));
  assign exp_dat  = exp_full[DW-1:0];
  assign mismatch = pipe_vld && (bus.ram_rd_data != exp_dat);

  // Sticky error status per sweep; cleared only by an accepted start, count saturates at DEPTH.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (start_acc) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (mismatch) begin
      err_flag_q <= 1'b1;
      if (err_cnt_q != (AW+1)'(DEPTH)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end
`else
  logic unused_chk;

  // No comparator in this build: status is constant zero, the tag address is not consumed.
  assign unused_chk = ^{pipe_addr, 32'(DATA_BASE)};
  assign err_flag_q = 1'b0;
  assign err_cnt_q  = '0;
`endif

  assign bus.ram_rd_en   = (state_q == ST_READ);
  assign bus.ram_rd_addr = addr_q;
  assign bus.rd_vld      = rd_vld_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err_flag    = err_flag_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: one instance per read latency (1 and 2) sharing a RAM image and start/reset.
// Latency: expectations are per-cycle offsets from the start cycle.
// Backpressure: n/a.
module tb_ram_rd_check;

  localparam int DEPTH     = 32;
  localparam int DATA_BASE = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic [7:0] mem [DEPTH];
  logic [7:0] ram2_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_rd_check_if #(.AW(5), .DW(8)) b1 ();
  ram_rd_check_if #(.AW(5), .DW(8)) b2 ();

  assign b1.start = start;
  assign b2.start = start;

  ram_rd_check #(.DEPTH(DEPTH), .AW(5), .DW(8), .RD_LAT(1), .DATA_BASE(DATA_BASE)) dut1 (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (b1)
  );

  ram_rd_check #(.DEPTH(DEPTH), .AW(5), .DW(8), .RD_LAT(2), .DATA_BASE(DATA_BASE)) dut2 (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (b2)
  );

  // Plain RAM read port: data one cycle after the enable.
  always_ff @(posedge clk) begin
    if (b1.ram_rd_en) b1.ram_rd_data <= mem[b1.ram_rd_addr];
  end

  // RAM with output register: data two cycles after the enable.
  always_ff @(posedge clk) begin
    if (b2.ram_rd_en) ram2_s <= mem[b2.ram_rd_addr];
    b2.ram_rd_data <= ram2_s;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected behaviour of one instance in cycle c after the start cycle.
  // r is the cycle in which reset is held (0 = none); e_ef/e_ec are the sweep's final status.
  task automatic check_dut(input int lat, input int c, input int r, input logic e_ef,
                           input logic [5:0] e_ec, input logic en, input logic [4:0] addr,
                           input logic vld, input logic [7:0] data, input logic busy,
                           input logic done, input logic ef, input logic [5:0] ec);
    string p;
    int    last_c;
    p = $sformatf("L%0d c%0d", lat, c);
    last_c = DEPTH + lat + 1;
    if (r > 0 && c > r) begin
      chk({p, " rst en"},   en,   0);
      chk({p, " rst addr"}, addr, 0);
      chk({p, " rst vld"},  vld,  0);
      chk({p, " rst busy"}, busy, 0);
      chk({p, " rst done"}, done, 0);
      chk({p, " rst ef"},   ef,   0);
      chk({p, " rst ec"},   ec,   0);
      if (c == r + 1) chk({p, " rst data"}, data, 0);
    end else begin
      chk({p, " en"},   en,   (c >= 1 && c <= DEPTH));
      chk({p, " addr"}, addr, (c >= 1 && c <= DEPTH) ? c - 1 : 0);
      chk({p, " vld"},  vld,  (c >= lat + 2 && c <= last_c));
      if (c >= lat + 2 && c <= last_c) chk({p, " data"}, data, mem[c - lat - 2]);
      chk({p, " busy"}, busy, (c >= 1 && c <= last_c));
      chk({p, " done"}, done, (c == last_c));
      if (c == 1) begin
        chk({p, " clr ef"}, ef, 0);
        chk({p, " clr ec"}, ec, 0);
      end
      if (c >= last_c) begin
        chk({p, " ef"}, ef, e_ef);
        chk({p, " ec"}, ec, e_ec);
      end
    end
  endtask

  // One sweep: start pulse, optional extra start at cycle xs, optional reset at cycle r.
  task automatic sweep(input int xs, input int r);
    int         nbad;
    logic       e_ef;
    logic [5:0] e_ec;
    nbad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] != 8'(a + DATA_BASE)) nbad++;
    end
`ifdef RAM_RD_CHECK_EN
    e_ef = (nbad > 0);
    e_ec = 6'((nbad > DEPTH) ? DEPTH : nbad);
`else
    e_ef = 1'b0;
    e_ec = 6'd0;
`endif
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      check_dut(1, c, r, e_ef, e_ec, b1.ram_rd_en, b1.ram_rd_addr, b1.rd_vld, b1.rd_data,
                b1.busy, b1.done, b1.err_flag, b1.err_cnt);
      check_dut(2, c, r, e_ef, e_ec, b2.ram_rd_en, b2.ram_rd_addr, b2.rd_vld, b2.rd_data,
                b2.busy, b2.done, b2.err_flag, b2.err_cnt);
      start = (c == xs);
      rst   = (c == r);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic load_clean();
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a + DATA_BASE);
  endtask

  initial begin
    int xs;
    int r;
    load_clean();
    repeat (3) @(negedge clk);
    chk("reset busy1", b1.busy, 0);
    chk("reset vld1",  b1.rd_vld, 0);
    chk("reset data1", b1.rd_data, 0);
    chk("reset ec1",   b1.err_cnt, 0);
    chk("reset busy2", b2.busy, 0);
    chk("reset en2",   b2.ram_rd_en, 0);
    chk("reset done2", b2.done, 0);
    chk("reset ef2",   b2.err_flag, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean sweep.
    sweep(0, 0);
    // Two corrupted words.
    mem[5]  = 8'hA5;
    mem[31] = 8'h00;
    sweep(0, 0);
    // Clean RAM, extra start mid-sweep: ignored, and errors from the previous sweep are cleared.
    load_clean();
    sweep(10, 0);
    // Reset mid-sweep, then a full clean sweep.
    mem[3] = 8'h77;
    sweep(0, 15);
    load_clean();
    sweep(0, 0);
    // Every word wrong: count reaches DEPTH without wrapping.
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a + DATA_BASE) ^ 8'h80;
    sweep(0, 0);

    // Randomized sweeps.
    for (int it = 0; it < 12; it++) begin
      load_clean();
      repeat ($urandom_range(0, 4)) mem[$urandom_range(0, DEPTH - 1)] = 8'($urandom);
      xs = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 33) : 0;
      r  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 36) : 0;
      if (r > 0 && xs >= r) xs = 0;
      sweep(xs, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
